// File: rtl/alu_resp_deserializer.sv
// Serial ALU response receiver: 11-bit packets into result, flags and errors.
// Frames a 4xDATA+CTL response or a single error CMD, with CRC3/parity check.
module alu_resp_deserializer #(
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic [2:0]  err_flags,
  output logic        resp_is_err,
  output logic        chk_ok,
  output logic        proto_err,
  output logic        resp_valid
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RX,
    S_DONE,
    S_SYNC
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        type_q, type_d;
  logic [7:0]  pay_q, pay_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [31:0] shadow_q, shadow_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic [2:0]  err_flags_q, err_flags_d;
  logic        is_err_q, is_err_d;
  logic        chk_ok_q, chk_ok_d;
  logic        perr_q, perr_d;
  logic        valid_q, valid_d;
  logic        do_norm, do_err, do_abort;

  function automatic logic [2:0] crc3(input logic [31:0] c,
                                      input logic [3:0] f);
    logic [36:0] m;
    logic [2:0]  crc;
    logic        fb;
    m   = {c, 1'b0, f};
    crc = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb  = m[i] ^ crc[2];
      crc = {crc[1], crc[0] ^ fb, fb};
    end
    return crc;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    type_d      = type_q;
    pay_d       = pay_q;
    bcnt_d      = bcnt_q;
    shadow_d    = shadow_q;
    idle_d      = idle_q;
    result_d    = result_q;
    flags_d     = flags_q;
    err_flags_d = err_flags_q;
    is_err_d    = is_err_q;
    chk_ok_d    = chk_ok_q;
    perr_d      = perr_q;
    valid_d     = 1'b0;
    do_norm     = 1'b0;
    do_err      = 1'b0;
    do_abort    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!sin) begin
          state_d = S_RX;
          cnt_d   = 4'd0;
          idle_d  = '0;
        end else if (bcnt_q != 3'd0) begin
          if (idle_q != IW'(IDLE_TIMEOUT)) idle_d = idle_q + IW'(1);
          if (idle_d == IW'(IDLE_TIMEOUT)) begin
            do_abort = 1'b1;
            idle_d   = '0;
          end
        end
      end
      S_RX: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd0) begin
          type_d = sin;
        end else if (cnt_q <= 4'd8) begin
          pay_d = {pay_q[6:0], sin};
        end else if (!sin) begin
          do_abort = 1'b1;
          state_d  = S_SYNC;
        end else begin
          state_d = S_DONE;
          if (!type_q) begin
            if (bcnt_q < 3'd4) begin
              shadow_d = {shadow_q[23:0], pay_q};
              bcnt_d   = bcnt_q + 3'd1;
            end else begin
              do_abort = 1'b1;
            end
          end else if (bcnt_q == 3'd4 && !pay_q[7]) begin
            do_norm = 1'b1;
          end else if (bcnt_q == 3'd0 && pay_q[7]) begin
            do_err = 1'b1;
          end else begin
            do_abort = 1'b1;
          end
        end
      end
      S_DONE: begin
        // a start bit right after the stop bit is legal
        if (!sin) begin
          state_d = S_RX;
          cnt_d   = 4'd0;
          idle_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SYNC: begin
        if (sin) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (do_norm) begin
      result_d    = shadow_q;
      flags_d     = pay_q[6:3];
      chk_ok_d    = (crc3(shadow_q, pay_q[6:3]) == pay_q[2:0]);
      is_err_d    = 1'b0;
      err_flags_d = 3'b000;
      perr_d      = 1'b0;
    end
    if (do_err) begin
      is_err_d    = 1'b1;
      err_flags_d = pay_q[6:4];
      chk_ok_d    = ~^pay_q;
      perr_d      = 1'b0;
    end
    if (do_abort) begin
      is_err_d = 1'b0;
      chk_ok_d = 1'b0;
      perr_d   = 1'b1;
    end
    if (do_norm || do_err || do_abort) begin
      valid_d = 1'b1;
      bcnt_d  = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      type_q      <= 1'b0;
      pay_q       <= 8'd0;
      bcnt_q      <= 3'd0;
      shadow_q    <= 32'd0;
      idle_q      <= '0;
      result_q    <= 32'd0;
      flags_q     <= 4'd0;
      err_flags_q <= 3'd0;
      is_err_q    <= 1'b0;
      chk_ok_q    <= 1'b0;
      perr_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      type_q      <= type_d;
      pay_q       <= pay_d;
      bcnt_q      <= bcnt_d;
      shadow_q    <= shadow_d;
      idle_q      <= idle_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      err_flags_q <= err_flags_d;
      is_err_q    <= is_err_d;
      chk_ok_q    <= chk_ok_d;
      perr_q      <= perr_d;
      valid_q     <= valid_d;
    end
  end

  assign result      = result_q;
  assign flags       = flags_q;
  assign err_flags   = err_flags_q;
  assign resp_is_err = is_err_q;
  assign chk_ok      = chk_ok_q;
  assign proto_err   = perr_q;
  assign resp_valid  = valid_q;

endmodule

// File: tb/tb_alu_resp_deserializer.sv
// Directed bench for alu_resp_deserializer.
// Drives sin on falling edges and samples outputs on falling edges.
module tb_alu_resp_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;
  logic [2:0]  err_flags;
  logic        resp_is_err;
  logic        chk_ok;
  logic        proto_err;
  logic        resp_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  logic [31:0] cap_res [0:15];
  logic        cap_chk [0:15];
  logic [3:0]  cap_flg [0:15];

  alu_resp_deserializer #(.IDLE_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .result(result), .flags(flags), .err_flags(err_flags),
    .resp_is_err(resp_is_err), .chk_ok(chk_ok),
    .proto_err(proto_err), .resp_valid(resp_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      cap_res[pulses[3:0]] = result;
      cap_chk[pulses[3:0]] = chk_ok;
      cap_flg[pulses[3:0]] = flags;
      pulses = pulses + 1;
    end
  end

  // reference CRC3: long division by x^3+x+1 over {C, 0, flags}
  function automatic logic [2:0] ref_crc(input logic [31:0] c,
                                         input logic [3:0] f);
    logic [39:0] r;
    r = {c, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic logic [7:0] ctl(input logic [31:0] c,
                                     input logic [3:0] f);
    return {1'b0, f, ref_crc(c, f)};
  endfunction

  task automatic send_pkt(input logic t, input logic [7:0] b,
                          input logic stop);
    logic [10:0] fr;
    fr = {1'b0, t, b, stop};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      sin = fr[i];
    end
  endtask

  task automatic send_resp(input logic [31:0] c, input logic [3:0] f);
    for (int i = 3; i >= 0; i--) send_pkt(1'b0, c[i*8 +: 8], 1'b1);
    send_pkt(1'b1, ctl(c, f), 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sin = 1'b1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if (result !== 32'd0 || flags !== 4'd0 || err_flags !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h/%h/%h want 0", result, flags,
               err_flags);
    end
    n_cmp++;
    if ({resp_is_err, chk_ok, proto_err, resp_valid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 0000",
               {resp_is_err, chk_ok, proto_err, resp_valid});
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_normal;
    int p0;
    p0 = pulses;
    send_pkt(1'b0, 8'h00, 1'b1);
    send_pkt(1'b0, 8'h00, 1'b1);
    send_pkt(1'b0, 8'h00, 1'b1);
    send_pkt(1'b0, 8'h05, 1'b1);
    send_pkt(1'b1, 8'h01, 1'b1);
    idle(1);
    n_cmp++;
    if (resp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL norm_valid_lat: got %b want 1", resp_valid);
    end
    n_cmp++;
    if (result !== 32'h5 || flags !== 4'h0) begin
      n_bad++;
      $display("FAIL norm_result: got %h/%h want 00000005/0", result, flags);
    end
    n_cmp++;
    if ({chk_ok, resp_is_err, proto_err} !== 3'b100) begin
      n_bad++;
      $display("FAIL norm_status: got %b want 100",
               {chk_ok, resp_is_err, proto_err});
    end
    idle(4);
    n_cmp++;
    if (pulses - p0 !== 1 || resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL norm_pulses: got %0d want 1", pulses - p0);
    end
  endtask

  task automatic test_bad_crc;
    send_pkt(1'b0, 8'h00, 1'b1);
    send_pkt(1'b0, 8'h00, 1'b1);
    send_pkt(1'b0, 8'h00, 1'b1);
    send_pkt(1'b0, 8'h05, 1'b1);
    send_pkt(1'b1, 8'h02, 1'b1);
    idle(1);
    n_cmp++;
    if (resp_valid !== 1'b1 || chk_ok !== 1'b0 || proto_err !== 1'b0) begin
      n_bad++;
      $display("FAIL badcrc_status: got v%b c%b p%b want v1 c0 p0",
               resp_valid, chk_ok, proto_err);
    end
    n_cmp++;
    if (result !== 32'h5) begin
      n_bad++;
      $display("FAIL badcrc_result: got %h want 00000005", result);
    end
    idle(2);
  endtask

  task automatic test_error_frame;
    send_pkt(1'b1, 8'hC9, 1'b1);
    idle(1);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_is_err !== 1'b1 ||
        err_flags !== 3'b100) begin
      n_bad++;
      $display("FAIL errfr_flags: got v%b e%b f%b want v1 e1 f100",
               resp_valid, resp_is_err, err_flags);
    end
    n_cmp++;
    if (chk_ok !== 1'b1 || result !== 32'h5 || proto_err !== 1'b0) begin
      n_bad++;
      $display("FAIL errfr_chk: got c%b r%h p%b want c1 r00000005 p0",
               chk_ok, result, proto_err);
    end
    idle(2);
    send_pkt(1'b1, 8'hC8, 1'b1);
    idle(1);
    n_cmp++;
    if (resp_valid !== 1'b1 || chk_ok !== 1'b0 || resp_is_err !== 1'b1) begin
      n_bad++;
      $display("FAIL errfr_parity: got v%b c%b e%b want v1 c0 e1",
               resp_valid, chk_ok, resp_is_err);
    end
    idle(2);
  endtask

  task automatic test_timeout;
    int p0;
    int k;
    p0 = pulses;
    k = 0;
    send_pkt(1'b0, 8'h11, 1'b1);
    send_pkt(1'b0, 8'h22, 1'b1);
    for (int i = 1; i <= 100 && k == 0; i++) begin
      @(negedge clk);
      sin = 1'b1;
      if (resp_valid === 1'b1) k = i;
    end
    n_cmp++;
    if (k < 60 || k > 70) begin
      n_bad++;
      $display("FAIL timeout_when: got cycle %0d want 60..70", k);
    end
    n_cmp++;
    if (proto_err !== 1'b1 || chk_ok !== 1'b0 || resp_is_err !== 1'b0 ||
        result !== 32'h5) begin
      n_bad++;
      $display("FAIL timeout_out: got p%b c%b e%b r%h want p1 c0 e0 r5",
               proto_err, chk_ok, resp_is_err, result);
    end
    idle(80);
    n_cmp++;
    if (pulses - p0 !== 1) begin
      n_bad++;
      $display("FAIL timeout_pulses: got %0d want 1", pulses - p0);
    end
  endtask

  task automatic test_framing;
    int p0;
    p0 = pulses;
    send_pkt(1'b0, 8'h33, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sin = 1'b0;
    end
    n_cmp++;
    if (pulses - p0 !== 1 || proto_err !== 1'b1) begin
      n_bad++;
      $display("FAIL framing_abort: got %0d pulses p%b want 1 p1",
               pulses - p0, proto_err);
    end
    idle(3);
    send_resp(32'h12345678, 4'b0110);
    idle(1);
    n_cmp++;
    if (resp_valid !== 1'b1 || result !== 32'h12345678 ||
        flags !== 4'b0110) begin
      n_bad++;
      $display("FAIL framing_resync: got v%b r%h f%b want v1 12345678 0110",
               resp_valid, result, flags);
    end
    n_cmp++;
    if (chk_ok !== 1'b1 || proto_err !== 1'b0) begin
      n_bad++;
      $display("FAIL framing_chk: got c%b p%b want c1 p0", chk_ok, proto_err);
    end
    idle(2);
  endtask

  task automatic test_reset_mid;
    logic [10:0] fr;
    send_pkt(1'b0, 8'hA1, 1'b1);
    send_pkt(1'b0, 8'hB2, 1'b1);
    fr = {2'b00, 8'hC3, 1'b1};
    for (int i = 10; i >= 4; i--) begin
      @(negedge clk);
      sin = fr[i];
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (result !== 32'd0 || flags !== 4'd0 ||
        {resp_is_err, chk_ok, proto_err, resp_valid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL midrst_outputs: got r%h f%h s%b want 0", result, flags,
               {resp_is_err, chk_ok, proto_err, resp_valid});
    end
    sin = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send_resp(32'hDEADBEEF, 4'b1010);
    idle(1);
    n_cmp++;
    if (resp_valid !== 1'b1 || result !== 32'hDEADBEEF ||
        flags !== 4'b1010) begin
      n_bad++;
      $display("FAIL midrst_result: got v%b r%h f%b want v1 deadbeef 1010",
               resp_valid, result, flags);
    end
    n_cmp++;
    if (chk_ok !== 1'b1 || proto_err !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_chk: got c%b p%b want c1 p0", chk_ok, proto_err);
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    int p0;
    p0 = pulses;
    send_resp(32'h01020304, 4'b0101);
    send_resp(32'hAABBCCDD, 4'b0011);
    idle(4);
    n_cmp++;
    if (pulses - p0 !== 2) begin
      n_bad++;
      $display("FAIL b2b_pulses: got %0d want 2", pulses - p0);
    end
    n_cmp++;
    if (cap_res[p0[3:0]] !== 32'h01020304 || cap_flg[p0[3:0]] !== 4'b0101 ||
        cap_chk[p0[3:0]] !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_first: got %h/%b/%b want 01020304/0101/1",
               cap_res[p0[3:0]], cap_flg[p0[3:0]], cap_chk[p0[3:0]]);
    end
    p0 = p0 + 1;
    n_cmp++;
    if (cap_res[p0[3:0]] !== 32'hAABBCCDD || cap_flg[p0[3:0]] !== 4'b0011 ||
        cap_chk[p0[3:0]] !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_second: got %h/%b/%b want aabbccdd/0011/1",
               cap_res[p0[3:0]], cap_flg[p0[3:0]], cap_chk[p0[3:0]]);
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_bad_crc;
    test_error_frame;
    test_timeout;
    test_framing;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
